// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        COMPUTE,
        SETTLE,
        DONE
    } ctrl_state_t;

    function automatic int load_words(input int height, input int buffer_size);
        return height * buffer_size;
    endfunction

    function automatic int feed_cycles(input int buffer_size, input int height, input int width);
        return buffer_size + height + width - 2;
    endfunction

    // Bits needed to hold 0..term; never narrower than one bit.
    function automatic int cnt_width(input int term);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_enable_gen.sv
// Maps the feed step to a diagonal-skewed enable vector: lane i active for steps i..i+K-1.
// Latency: combinational.
// Backpressure: none.
module skew_enable_gen #(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int SW = 4
) (
    input  logic [SW-1:0] step,
    output logic [N-1:0]  en
);

    always_comb begin
        en = '0;
        for (int i = 0; i < N; i++) begin
            en[i] = (int'(step) >= i) && (int'(step) < i + K);
        end
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the systolic array: load operands, skewed feed, settle, report done.
// Latency: request -> done after LOAD_WORDS + 1 + FEED_CYCLES + RESULT_LAT cycles.
// Backpressure: none; requests outside IDLE/DONE are dropped.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int  DATA_WIDTH  = 8,
    parameter int  WIDTH       = 4,
    parameter int  HEIGHT      = 4,
    parameter int  BUFFER_SIZE = 4,
    parameter int  RESULT_LAT  = 1,
    localparam int LOAD_WORDS  = load_words(HEIGHT, BUFFER_SIZE),
    localparam int FEED_CYCLES = feed_cycles(BUFFER_SIZE, HEIGHT, WIDTH),
    localparam int AW          = cnt_width(LOAD_WORDS - 1),
    localparam int SW          = cnt_width(FEED_CYCLES - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_valid,
    output logic              read_data,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic              start_compute,
    output logic [HEIGHT-1:0] row_feed_en,
    output logic [WIDTH-1:0]  col_feed_en,
    output logic [SW-1:0]     step,
    output logic              busy,
    output logic              done
);

    localparam int RW = cnt_width(RESULT_LAT - 1);
    localparam logic [AW-1:0] LOAD_LAST   = AW'(LOAD_WORDS - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(FEED_CYCLES - 1);
    localparam logic [RW-1:0] SETTLE_LAST = RW'(RESULT_LAT - 1);

    // A and B stream side by side, so both matrices must hold the same word count.
    if (LOAD_WORDS != BUFFER_SIZE * WIDTH) begin : g_shape_chk
        $error("systolic_seq_ctrl: HEIGHT*BUFFER_SIZE must equal BUFFER_SIZE*WIDTH");
    end
    if (DATA_WIDTH < 1) begin : g_dw_chk
        $error("systolic_seq_ctrl: DATA_WIDTH must be positive");
    end

    ctrl_state_t       state, state_nxt;
    logic [AW-1:0]     load_cnt;
    logic [RW-1:0]     settle_cnt;
    logic [HEIGHT-1:0] row_skew;
    logic [WIDTH-1:0]  col_skew;

    skew_enable_gen #(.N(HEIGHT), .K(BUFFER_SIZE), .SW(SW)) u_row_skew (
        .step (step),
        .en   (row_skew)
    );

    skew_enable_gen #(.N(WIDTH), .K(BUFFER_SIZE), .SW(SW)) u_col_skew (
        .step (step),
        .en   (col_skew)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_cnt   <= '0;
            step       <= '0;
            settle_cnt <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
        end else begin
            state <= state_nxt;
            wr_en <= read_data;
            if (wr_en) begin
                wr_addr <= (wr_addr == LOAD_LAST) ? '0 : wr_addr + 1'b1;
            end
            load_cnt   <= (state == LOAD && load_cnt != LOAD_LAST) ? load_cnt + 1'b1 : '0;
            step       <= (state == COMPUTE && step != STEP_LAST) ? step + 1'b1 : '0;
            settle_cnt <= (state == SETTLE && settle_cnt != SETTLE_LAST) ? settle_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt     = state;
        read_data     = 1'b0;
        start_compute = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        row_feed_en   = '0;
        col_feed_en   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (data_valid) state_nxt = LOAD;
            end
            LOAD: begin
                read_data = 1'b1;
                if (load_cnt == LOAD_LAST) state_nxt = FLUSH;
            end
            FLUSH: state_nxt = COMPUTE;
            COMPUTE: begin
                start_compute = (step == '0);
                row_feed_en   = row_skew;
                col_feed_en   = col_skew;
                if (step == STEP_LAST) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (data_valid) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the 4x4 weight/activation systolic array (TOP).
- Accepts a host "data_valid" request and streams matrix A and B words from the host into the operand buffers over "read_data".
- Issues "start_compute" and a per-row/per-column skewed feed schedule, then signals "done" once every PE result is final.
- Sits between the host/testbench interface and the operand buffers + PE grid. It replaces the ad-hoc sequencing currently spread across TOP.

Parameters:
- DATA_WIDTH, 8, operand width; informational here, it drives no datapath.
- WIDTH, 4, array columns (B streams).
- HEIGHT, 4, array rows (A streams).
- BUFFER_SIZE, 4, inner dimension K (products accumulated per PE).
- RESULT_LAT, 1, cycles from a PE's last operand to a stable result.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- data_valid  in  1  host request to load and run one matrix product; sampled only in IDLE or DONE.
- read_data  out  1  fetch strobe to host; the host presents word n of A and B one cycle after the n-th cycle this is high.
- wr_en  out  1  operand buffer write enable (read_data delayed 1 cycle).
- wr_addr  out  $clog2(LOAD_WORDS)  buffer write address, 0..LOAD_WORDS-1, aligned with wr_en.
- start_compute  out  1  one-cycle pulse; PEs clear accumulators and the buffer read pointers reset.
- row_feed_en  out  HEIGHT  row i drives operand A[i][step-i] into column 0 when high.
- col_feed_en  out  WIDTH  column j drives operand B[step-j][j] into row 0 when high.
- step  out  $clog2(FEED_CYCLES)  current feed step t.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  level; results valid in all PEs.

Behaviour:
- Derived constants:
  - LOAD_WORDS = HEIGHT*BUFFER_SIZE. This must equal BUFFER_SIZE*WIDTH; elaboration error otherwise. A and B stream in parallel, one word each per cycle.
  - FEED_CYCLES = BUFFER_SIZE + HEIGHT + WIDTH - 2.
- Reset:
  - State returns to IDLE on the first rising edge with rst_n=0, including mid-operation.
  - All outputs 0; counters 0.
- States: IDLE, LOAD, FLUSH, COMPUTE, SETTLE, DONE.
- IDLE: data_valid=1 -> LOAD.
- LOAD:
  - read_data=1 for exactly LOAD_WORDS consecutive cycles; a load counter counts 0..LOAD_WORDS-1.
  - On the cycle the counter reaches LOAD_WORDS-1 -> FLUSH.
- FLUSH: single cycle; read_data=0, wr_en=1 carrying the last word -> COMPUTE.
- wr_en/wr_addr:
  - wr_en is read_data registered; wr_addr increments per wr_en and wraps to 0 after LOAD_WORDS-1.
  - Exactly LOAD_WORDS writes per run, addresses 0..LOAD_WORDS-1 in order.
- COMPUTE:
  - start_compute=1 on the first COMPUTE cycle only.
  - step counts 0..FEED_CYCLES-1, one per cycle.
  - row_feed_en[i] = (i <= step < i+BUFFER_SIZE).
  - col_feed_en[j] = (j <= step < j+BUFFER_SIZE).
  - After step=FEED_CYCLES-1 -> SETTLE; step resets to 0 and all feed enables go to 0.
- SETTLE: counts RESULT_LAT cycles, then -> DONE.
- DONE:
  - done=1, held until leaving DONE.
  - data_valid=1 clears done on the next edge and enters LOAD, so back-to-back runs are allowed.
- Ignored inputs: data_valid during LOAD, FLUSH, COMPUTE or SETTLE is ignored, with no queuing.
- Latency:
  - data_valid sampled -> done rises after LOAD_WORDS + 1 + FEED_CYCLES + RESULT_LAT cycles.
  - Defaults: 16 + 1 + 10 + 1 = 28 cycles.
- Counter widths: every counter is sized by $clog2 of its terminal count + 1; no counter overflows at legal parameters.
- Reset asserted during COMPUTE: feed enables and start_compute are 0 from that edge onward. No partial done.

Decomposition:
- Package systolic_pkg holds:
  - the state enum ctrl_state_t;
  - functions for LOAD_WORDS and FEED_CYCLES;
  - the counter-width helper.
- Sub-module skew_enable_gen(N, K) maps step to an N-bit feed-enable vector. It is instantiated twice, once for rows and once for columns.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, data_valid=0 -> all outputs 0, busy=0 for 20 cycles.
- Nominal run (defaults): data_valid pulse at cycle 0, with the host feeding matrix_A/matrix_B files:
  - read_data high cycles 1..16;
  - wr_en high 2..17 with wr_addr 0..15;
  - start_compute pulse at 18;
  - done rises at 29;
  - PE(i,j) results equal the golden sum over k of A[i][k]*B[k][j].
- Skew check: during COMPUTE at step=3, row_feed_en=4'b1111; at step=5, 4'b1100; at step=9, 4'b0000 (PE(3,3) last operand at step 9).
- Ignored request: data_valid pulses at cycles 5 and 20 -> no second load; exactly 16 wr_en pulses, done at 29.
- Back-to-back: data_valid asserted in the first DONE cycle -> done falls the next cycle, read_data restarts, and the second done arrives 28 cycles after the request.
- Mid-run reset: rst_n=0 for one cycle at COMPUTE step 4 -> next cycle state IDLE, feed enables 0, done never asserts. A subsequent data_valid completes a normal run.
